// File: rtl/uart_rx_cfg_if.sv
// Receive-side handshake bundle of uart_rx_cfg: held frame, its status flags
// and the consumer's accept strobe.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 break_det;
    logic                 overrun_err;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err, break_det, overrun_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, break_det, overrun_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: oversampled 2-of-3 majority bit decisions, runtime
// parity/stop selection latched per frame, break detection, one-deep output hold.
module uart_rx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVS_FACTOR = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick_ovs,
    input  logic             rx_pin,
    input  logic [1:0]       parity_mode,
    input  logic             stop_bits2,
    output logic             busy,
    uart_rx_cfg_if.master    rx_if
);

    localparam int CW = $clog2(OVS_FACTOR);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] TICK_LO   = CW'(OVS_FACTOR / 2 - 1);
    localparam logic [CW-1:0] TICK_MID  = CW'(OVS_FACTOR / 2);
    localparam logic [CW-1:0] TICK_HI   = CW'(OVS_FACTOR / 2 + 1);
    localparam logic [CW-1:0] TICK_LAST = CW'(OVS_FACTOR - 1);
    localparam logic [BW-1:0] BITS_ALL  = BW'(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRK_WAIT
    } state_t;

    state_t               state_q;
    logic [1:0]           sync_q;
    logic [CW-1:0]        os_cnt_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic [1:0]           smp_q;
    logic                 par_en_q;
    logic                 par_odd_q;
    logic                 stop2_q;
    logic                 stop_idx_q;
    logic                 par_err_q;
    logic                 fe_q;
    logic                 brk_q;
    logic                 done_q;
    logic                 busy_q;

    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 pe_out_q;
    logic                 fe_out_q;
    logic                 brk_out_q;
    logic                 ovr_q;

    logic line;
    logic maj;
    logic at_hi;
    logic at_last;

    assign line    = sync_q[1];
    // Samples at MID-1 and MID are stored; the MID+1 sample is the live line.
    assign maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & line) | (smp_q[1] & line);
    assign at_hi   = tick_ovs && (os_cnt_q == TICK_HI);
    assign at_last = tick_ovs && (os_cnt_q == TICK_LAST);

    // NOTE: every flop below, including the synchronizer and the data shift
    // register, is cleared by the asynchronous reset so a mid-frame reset
    // leaves no stale state behind.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
        end else begin
            // NOTE: non-blocking assignments keep the two stages as two flops.
            sync_q <= {sync_q[0], rx_pin};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            os_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            smp_q      <= 2'b11;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            par_err_q  <= 1'b0;
            fe_q       <= 1'b0;
            brk_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (tick_ovs && state_q != S_IDLE && state_q != S_BRK_WAIT) begin
                os_cnt_q <= (os_cnt_q == TICK_LAST) ? '0 : os_cnt_q + 1'b1;
                if (os_cnt_q == TICK_LO)  smp_q[0] <= line;
                if (os_cnt_q == TICK_MID) smp_q[1] <= line;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (tick_ovs && !line) begin
                        state_q    <= S_START;
                        busy_q     <= 1'b1;
                        os_cnt_q   <= '0;
                        bit_cnt_q  <= '0;
                        stop_idx_q <= 1'b0;
                        par_en_q   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                        par_odd_q  <= (parity_mode == 2'b10);
                        stop2_q    <= stop_bits2;
                        par_err_q  <= 1'b0;
                        fe_q       <= 1'b0;
                        brk_q      <= 1'b0;
                    end
                end

                S_START: begin
                    if (at_hi && maj) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (at_last) begin
                        state_q <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (at_hi) begin
                        shreg_q   <= {maj, shreg_q[DATA_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end else if (at_last && bit_cnt_q == BITS_ALL) begin
                        state_q <= par_en_q ? S_PARITY : S_STOP;
                    end
                end

                S_PARITY: begin
                    if (at_hi) begin
                        par_err_q <= maj ^ (^shreg_q) ^ par_odd_q;
                    end else if (at_last) begin
                        state_q <= S_STOP;
                    end
                end

                S_STOP: begin
                    if (at_hi) begin
                        if (!maj) fe_q <= 1'b1;
                        // A line stuck low through the first stop bit is a break,
                        // reported at once rather than after the second stop bit.
                        if (!stop_idx_q && !maj && shreg_q == '0) begin
                            brk_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_BRK_WAIT;
                        end else if (stop_idx_q == stop2_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else if (at_last) begin
                        stop_idx_q <= 1'b1;
                    end
                end

                S_BRK_WAIT: begin
                    if (line) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Output hold register: a handshake in the completion cycle frees the slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            pe_out_q   <= 1'b0;
            fe_out_q   <= 1'b0;
            brk_out_q  <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            if (rx_valid_q && rx_if.rx_ready) begin
                rx_valid_q <= 1'b0;
                ovr_q      <= 1'b0;
            end
            if (done_q) begin
                if (!rx_valid_q || rx_if.rx_ready) begin
                    rx_data_q  <= shreg_q;
                    pe_out_q   <= par_err_q;
                    fe_out_q   <= fe_q | brk_q;
                    brk_out_q  <= brk_q;
                    rx_valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end
        end
    end

    assign busy              = busy_q;
    assign rx_if.rx_data     = rx_data_q;
    assign rx_if.rx_valid    = rx_valid_q;
    assign rx_if.parity_err  = pe_out_q;
    assign rx_if.frame_err   = fe_out_q;
    assign rx_if.break_det   = brk_out_q;
    assign rx_if.overrun_err = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: serial frames are driven bit by bit, expectations go
// into a scoreboard queue and are compared when the receiver presents a frame.
module tb_uart_rx_cfg;

    localparam int DB       = 8;
    localparam int OVS      = 16;
    localparam int TDIV     = 4;
    localparam int BIT_CLKS = OVS * TDIV;

    logic       clk         = 1'b0;
    logic       reset_n     = 1'b0;
    logic       tick_ovs    = 1'b0;
    logic       rx_pin      = 1'b1;
    logic [1:0] parity_mode = 2'b00;
    logic       stop_bits2  = 1'b0;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [DB-1:0] data;
        logic          pe;
        logic          fe;
        logic          brk;
    } exp_t;

    exp_t sb_q[$];

    uart_rx_cfg_if #(.DATA_BITS(DB)) rx_if ();

    uart_rx_cfg #(
        .DATA_BITS (DB),
        .OVS_FACTOR(OVS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick_ovs   (tick_ovs),
        .rx_pin     (rx_pin),
        .parity_mode(parity_mode),
        .stop_bits2 (stop_bits2),
        .busy       (busy),
        .rx_if      (rx_if)
    );

    always #5 clk = ~clk;

    initial begin
        rx_if.rx_ready = 1'b0;
        forever begin
            repeat (TDIV - 1) @(posedge clk);
            #1 tick_ovs = 1'b1;
            @(posedge clk);
            #1 tick_ovs = 1'b0;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_bit();
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    // Drives one frame, aligned 1 time unit after a clk edge, and two idle bits.
    task automatic send_frame(input logic [DB-1:0] d, input logic [1:0] pmode,
                              input bit bad_par, input bit two_stop,
                              input bit stop_val, input bit scramble, input bit push);
        logic par;
        bit   par_on;
        exp_t e;
        par_on = (pmode == 2'b01) || (pmode == 2'b10);
        par    = ^d;
        if (pmode == 2'b10) par = ~par;
        if (bad_par) par = ~par;
        if (push) begin
            e.data = d;
            e.pe   = bad_par && par_on;
            e.fe   = !stop_val;
            e.brk  = (d == '0) && !stop_val;
            sb_q.push_back(e);
        end
        parity_mode = pmode;
        stop_bits2  = two_stop;
        rx_pin      = 1'b0;
        wait_bit();
        if (scramble) begin
            parity_mode = 2'b00;
            stop_bits2  = ~two_stop;
        end
        for (int i = 0; i < DB; i++) begin
            rx_pin = d[i];
            wait_bit();
        end
        if (par_on) begin
            rx_pin = par;
            wait_bit();
        end
        rx_pin = stop_val;
        wait_bit();
        if (two_stop) begin
            rx_pin = 1'b1;
            wait_bit();
        end
        rx_pin = 1'b1;
        repeat (2) wait_bit();
    endtask

    // Waits for a held frame, compares it with the scoreboard head, then accepts it.
    task automatic consume(input string tag, input bit exp_ovr);
        exp_t e;
        int   waited = 0;
        @(negedge clk);
        while (!rx_if.rx_valid && waited < 4 * BIT_CLKS) begin
            @(negedge clk);
            waited++;
        end
        if (!rx_if.rx_valid) begin
            check({tag, "_valid_timeout"}, 32'(rx_if.rx_valid), 32'd1);
        end else if (sb_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_data"},    32'(rx_if.rx_data),     32'(e.data));
            check({tag, "_par_err"}, 32'(rx_if.parity_err),  32'(e.pe));
            check({tag, "_frm_err"}, 32'(rx_if.frame_err),   32'(e.fe));
            check({tag, "_brk"},     32'(rx_if.break_det),   32'(e.brk));
            check({tag, "_ovr"},     32'(rx_if.overrun_err), 32'(exp_ovr));
            @(posedge clk);
            #1 rx_if.rx_ready = 1'b1;
            @(posedge clk);
            #1 rx_if.rx_ready = 1'b0;
            @(negedge clk);
            check({tag, "_valid_after_ready"}, 32'(rx_if.rx_valid),    32'd0);
            check({tag, "_ovr_after_ready"},   32'(rx_if.overrun_err), 32'd0);
        end
    endtask

    initial begin
        logic [DB-1:0] v;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(rx_if.rx_valid),    32'd0);
        check("rst_data",  32'(rx_if.rx_data),     32'd0);
        check("rst_flags", 32'({rx_if.parity_err, rx_if.frame_err, rx_if.break_det}), 32'd0);
        check("rst_ovr",   32'(rx_if.overrun_err), 32'd0);
        check("rst_busy",  32'(busy),              32'd0);

        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("idle_no_start", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        send_frame(8'h55, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        consume("8n1_55", 1'b0);

        send_frame(8'hA3, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        consume("8o2_a3_badpar", 1'b0);

        send_frame(8'h3C, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        consume("8e1_3c_badstop", 1'b0);

        send_frame(8'hC9, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        consume("mode11_c9", 1'b0);

        @(posedge clk);
        #1 rx_pin = 1'b0;
        repeat (4 * TDIV) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_during", 32'(busy), 32'd1);
        @(posedge clk);
        #1 rx_pin = 1'b1;
        wait_bit();
        @(negedge clk);
        check("glitch_valid", 32'(rx_if.rx_valid), 32'd0);
        check("glitch_busy",  32'(busy),           32'd0);

        sb_q.push_back('{data: '0, pe: 1'b0, fe: 1'b1, brk: 1'b1});
        parity_mode = 2'b00;
        stop_bits2  = 1'b0;
        @(posedge clk);
        #1 rx_pin = 1'b0;
        repeat (20) wait_bit();
        @(negedge clk);
        check("brk_busy_low",  32'(busy),           32'd1);
        check("brk_valid_low", 32'(rx_if.rx_valid), 32'd1);
        @(posedge clk);
        #1 rx_pin = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("brk_busy_released", 32'(busy), 32'd0);
        consume("break", 1'b0);
        wait_bit();

        send_frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        send_frame(8'h22, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("ovr_valid_held", 32'(rx_if.rx_valid),    32'd1);
        check("ovr_flag",       32'(rx_if.overrun_err), 32'd1);
        consume("overrun_11", 1'b1);

        send_frame(8'h5A, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("pre_reset_valid", 32'(rx_if.rx_valid), 32'd1);
        @(posedge clk);
        #1;
        v = 8'h7E;
        rx_pin = 1'b0;
        wait_bit();
        for (int i = 0; i < 3; i++) begin
            rx_pin = v[i];
            wait_bit();
        end
        rx_pin = v[3];
        repeat (BIT_CLKS / 2) @(posedge clk);
        @(negedge clk);
        check("mid_frame_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(rx_if.rx_valid), 32'd0);
        check("async_rst_data",  32'(rx_if.rx_data),  32'd0);
        check("async_rst_busy",  32'(busy),           32'd0);
        @(posedge clk);
        #1 rx_pin = 1'b1;
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b1;
        wait_bit();

        send_frame(v, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        consume("after_reset_7e", 1'b0);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
